// File: rtl/pos_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pos_decoder_pkg
//  Description : Shared definitions for the position decoder. Holds the
//                frame-engine state type and the default output width.
//                Optional feature macro used by this block:
//                POS_DECODER_RANGE_CHECK_EN (sticky out-of-range flag).
//  Revision    : 1.0 - initial release
// ============================================================================
package pos_decoder_pkg;

    // Default width of the reconstructed bit vector.
    localparam int DEFAULT_OUT_WIDTH = 32;

    // ACCUM : collecting position beats of a frame (in_ready=1)
    // EMIT  : presenting the reconstructed word     (out_valid=1)
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage : pos_decoder_pkg
`default_nettype wire

// File: rtl/pos_decoder_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Combinational index-to-one-hot decoder. An index that does
//                not address a bit of the output (i_pos >= OUT_WIDTH, only
//                reachable for non-power-of-2 widths) produces all zeros.
//  Ports       : i_pos    [POS_WIDTH-1:0] bit index
//                o_onehot [OUT_WIDTH-1:0] one-hot of i_pos, or zero
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter  int OUT_WIDTH = 32,
    localparam int POS_WIDTH = $clog2(OUT_WIDTH)
) (
    input  logic [POS_WIDTH-1:0] i_pos,
    output logic [OUT_WIDTH-1:0] o_onehot
);

    // Each output bit is a plain equality compare against its own index;
    // indices beyond OUT_WIDTH-1 have no matching bit, so they decode to 0.
    for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_bit
        localparam logic [POS_WIDTH-1:0] C_IDX = POS_WIDTH'(i);
        assign o_onehot[i] = (i_pos == C_IDX);
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/pos_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pos_decoder
//  Description : Rebuilds a bit vector from a framed stream of bit-position
//                beats. Each accepted beat ORs one-hot(in_pos) into an
//                accumulator and bumps a saturating beat counter. The beat
//                flagged in_last closes the frame; the word is then held on
//                the output side until the consumer takes it.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid / in_ready / in_pos / in_last   - position beats
//                out_valid / out_ready / out_word / out_count - result
//                err - sticky out-of-range flag
//  Options     : POS_DECODER_RANGE_CHECK_EN - when defined, err is set by
//                any accepted beat with in_pos >= OUT_WIDTH and held until
//                reset. When undefined, err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pos_decoder
    import pos_decoder_pkg::*;
#(
    parameter  int OUT_WIDTH = DEFAULT_OUT_WIDTH,
    localparam int POS_WIDTH = $clog2(OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [POS_WIDTH-1:0] in_pos,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_word,
    output logic [POS_WIDTH:0]   out_count,
    output logic                 err
);

    localparam logic [POS_WIDTH:0] C_COUNT_MAX = '1;
    localparam logic [POS_WIDTH:0] C_COUNT_ONE = {{POS_WIDTH{1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [OUT_WIDTH-1:0]   r_acc;
    logic [POS_WIDTH:0]     r_count;
    logic [OUT_WIDTH-1:0]   w_onehot;
    logic                   w_in_fire;
    logic                   w_out_fire;

    // ------------------------------------------------------------------
    // Position decode
    // ------------------------------------------------------------------
    onehot_dec #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_onehot_dec (
        .i_pos    (in_pos),
        .o_onehot (w_onehot)
    );

    // in_ready / out_valid come straight from the state, so these fire
    // terms already exclude beats offered while the other side is active.
    assign w_in_fire  = in_valid  & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                // Return to ACCUM on the handshake; in_ready only rises on
                // the next cycle, there is no same-cycle bypass.
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator and saturating beat counter
    // ------------------------------------------------------------------
    // Duplicate positions are naturally idempotent through the OR; an
    // out-of-range position decodes to zero but still counts as a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_out_fire) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_in_fire) begin
            r_acc <= r_acc | w_onehot;
            if (r_count != C_COUNT_MAX) begin
                r_count <= r_count + C_COUNT_ONE;
            end
        end
    end

    // The partial frame is kept private while accumulating; the result is
    // only exposed once the frame has closed.
    assign out_word  = (r_state == EMIT) ? r_acc   : '0;
    assign out_count = (r_state == EMIT) ? r_count : '0;

    // ------------------------------------------------------------------
    // Optional sticky out-of-range flag
    // ------------------------------------------------------------------
`ifdef POS_DECODER_RANGE_CHECK_EN
    localparam logic [POS_WIDTH:0] C_OUT_WIDTH_EXT = (POS_WIDTH + 1)'(OUT_WIDTH);

    logic w_out_of_range;
    logic r_err;

    // One extra bit so OUT_WIDTH itself is representable in the compare.
    assign w_out_of_range = ({1'b0, in_pos} >= C_OUT_WIDTH_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_in_fire && w_out_of_range) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule : pos_decoder
`default_nettype wire

// File: tb/tb_pos_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pos_decoder
//  Description : Self-checking bench for pos_decoder. Two instances run in
//                lockstep from the same stimulus: OUT_WIDTH=32 and
//                OUT_WIDTH=20 (non-power-of-2, exercises out-of-range
//                positions). A reference model builds each expected frame
//                result from the list of accepted positions and pushes it
//                into a scoreboard queue; a monitor compares the outputs of
//                both instances against the queue head every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pos_decoder;

`ifdef POS_DECODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_pos;
    logic        in_last;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] out_word32;
    logic [5:0]  out_count32;
    logic        in_ready20, out_valid20, err20;
    logic [19:0] out_word20;
    logic [5:0]  out_count20;

    always #5 clk = ~clk;

    pos_decoder #(.OUT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_pos(in_pos), .in_last(in_last), .out_valid(out_valid32),
        .out_ready(out_ready), .out_word(out_word32), .out_count(out_count32),
        .err(err32)
    );

    pos_decoder #(.OUT_WIDTH(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready20),
        .in_pos(in_pos), .in_last(in_last), .out_valid(out_valid20),
        .out_ready(out_ready), .out_word(out_word20), .out_count(out_count20),
        .err(err20)
    );

    typedef struct {
        logic [31:0] w32;
        logic [19:0] w20;
        int          cnt;
    } exp_t;

    exp_t sb[$];           // expected frame results, oldest first
    int   frame_pos[$];    // positions accepted so far in the current frame
    int   frame_stim[$];   // positions of the next frame to send
    bit   exp_err20 = 1'b0;
    bit   running   = 1'b0;
    int   ready_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word is the set of in-range positions seen in the
    // frame; the count is the number of beats, clipped at 63.
    function automatic logic [31:0] model_word(input int width);
        logic [31:0] r;
        r = '0;
        foreach (frame_pos[i]) begin
            if (frame_pos[i] < width) r[frame_pos[i]] = 1'b1;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Consumer-side ready generation
    // ---------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------------------------------------------------------
    // Monitor: checks both instances every cycle against the scoreboard
    // ---------------------------------------------------------------
    always @(negedge clk) begin
        if (running && rst_n) begin : mon
            logic exp_v;
            exp_v = (sb.size() != 0);
            check("valid32", out_valid32, exp_v);
            check("valid20", out_valid20, exp_v);
            check("in_ready32", in_ready32, !exp_v);
            check("in_ready20", in_ready20, !exp_v);
            check("err32", err32, 1'b0);
            check("err20", err20, exp_err20);
            if (exp_v) begin
                check("word32", out_word32, sb[0].w32);
                check("word20", out_word20, sb[0].w20);
                check("count32", out_count32, sb[0].cnt);
                check("count20", out_count20, sb[0].cnt);
                if (out_ready) void'(sb.pop_front());
            end else begin
                check("idle_word32", out_word32, 0);
                check("idle_word20", out_word20, 0);
                check("idle_count32", out_count32, 0);
                check("idle_count20", out_count20, 0);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic idle_cycle();
        in_valid = 1'b0;
        in_pos   = 5'($urandom_range(0, 31));
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int pos, input bit last);
        exp_t e;
        logic [31:0] w;
        int guard = 0;
        // While the block is emitting, offer junk beats that must be ignored.
        while (!in_ready32 && guard < 300) begin
            in_valid = 1'b1;
            in_pos   = 5'($urandom_range(0, 31));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_pos   = 5'(pos);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        frame_pos.push_back(pos);
        if (RC && pos >= 20) exp_err20 = 1'b1;
        if (last) begin
            e.w32 = model_word(32);
            w     = model_word(20);
            e.w20 = w[19:0];
            e.cnt = (frame_pos.size() > 63) ? 63 : frame_pos.size();
            sb.push_back(e);
            frame_pos.delete();
            // Result must be visible exactly one cycle after the last beat.
            check("latency_valid32", out_valid32, 1'b1);
            check("latency_valid20", out_valid20, 1'b1);
            check("latency_busy32", in_ready32, 1'b0);
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame_stim.size(); i++) begin
            send_beat(frame_stim[i], i == frame_stim.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
        end
        frame_stim.delete();
    endtask

    task automatic wait_drain();
        int guard = 0;
        ready_mode = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready32"}, in_ready32, 1'b1);
        check({tag, "_in_ready20"}, in_ready20, 1'b1);
        check({tag, "_valid32"}, out_valid32, 1'b0);
        check({tag, "_valid20"}, out_valid20, 1'b0);
        check({tag, "_word32"}, out_word32, 0);
        check({tag, "_word20"}, out_word20, 0);
        check({tag, "_count32"}, out_count32, 0);
        check({tag, "_count20"}, out_count20, 0);
        check({tag, "_err32"}, err32, 1'b0);
        check({tag, "_err20"}, err20, 1'b0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        frame_pos.delete();
        sb.delete();
        exp_err20 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n   = 1'b1;
        running = 1'b1;
        @(posedge clk); #1;

        // Mixed positions, top bit included; 31 is out of range for width 20.
        frame_stim = '{3, 7, 31};
        send_frame(1'b0);
        wait_drain();

        // Duplicate positions.
        frame_stim = '{5, 5};
        send_frame(1'b0);
        wait_drain();

        // Consumer stalls for 5 cycles; monitor sees the held result.
        ready_mode = 1;
        frame_stim = '{9, 12, 19};
        send_frame(1'b0);
        repeat (5) @(posedge clk);
        #1;
        wait_drain();

        // Reset after two beats of a frame discards them.
        send_beat(4, 1'b0);
        send_beat(6, 1'b0);
        do_reset();
        frame_stim = '{0};
        send_frame(1'b0);
        wait_drain();

        // Out-of-range position for the 20-bit instance; err stays sticky.
        frame_stim = '{25, 1};
        send_frame(1'b0);
        wait_drain();
        frame_stim = '{2};
        send_frame(1'b0);
        wait_drain();

        // Counter saturation: 64 beats of pos 0 then a last beat.
        for (int i = 0; i < 65; i++) frame_stim.push_back(0);
        send_frame(1'b0);
        wait_drain();

        // Randomized frames with random back-pressure and gaps.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = (f == 25) ? 70 : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) frame_stim.push_back($urandom_range(0, 31));
            if (f == 20) begin
                send_beat($urandom_range(0, 31), 1'b0);
                do_reset();
            end
            send_frame(1'b1);
            ready_mode = 2;
        end
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pos_decoder
`default_nettype wire

// File: doc/pos_decoder.md
POS_DECODER -- requirements
Module: pos_decoder

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32: width of the reconstructed bit vector.
REQ-002 SHALL have localparam POS_WIDTH = $clog2(OUT_WIDTH): width of a bit-position index.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: position beat offered.
REQ-006 SHALL have port in_ready  output  1: block accepts the position beat.
REQ-007 SHALL have port in_pos  input  POS_WIDTH: bit index to set.
REQ-008 SHALL have port in_last  input  1: final beat of the current frame.
REQ-009 SHALL have port out_valid  output  1: reconstructed word available.
REQ-010 SHALL have port out_ready  input  1: consumer takes the word.
REQ-011 SHALL have port out_word  output  OUT_WIDTH: OR of one-hot(in_pos) over all frame beats.
REQ-012 SHALL have port out_count  output  POS_WIDTH+1: number of beats accepted in the frame, saturating.
REQ-013 SHALL have port err  output  1: sticky out-of-range flag (see Configuration).

Function
REQ-014 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-015 SHALL, on each in_valid&in_ready beat in ACCUM, OR one-hot(in_pos) into the accumulator and increment the beat counter.
REQ-016 SHALL treat duplicate positions within a frame as idempotent on out_word; each still counts as one beat.
REQ-017 SHALL ignore, for out_word, any in_pos >= OUT_WIDTH (possible only for non-power-of-2 OUT_WIDTH); the beat is still counted.
REQ-018 SHALL saturate out_count at 2^(POS_WIDTH+1)-1; it SHALL NOT wrap.
REQ-019 SHALL transition ACCUM->EMIT on an accepted beat with in_last=1; out_valid rises the following cycle (latency 1) with out_word including that last beat.
REQ-020 SHALL hold out_word and out_count stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on out_valid&out_ready, clear the accumulator and counter and return to ACCUM; in_ready rises the following cycle (no same-cycle bypass).
REQ-022 SHALL present out_word=0 and out_count=0 while in ACCUM.
REQ-023 SHALL ignore in_pos/in_last when in_valid=0, and all input beats while in EMIT.

Reset
REQ-024 SHALL, on rst_n low (any time, including mid-frame or in EMIT), immediately enter ACCUM, clear accumulator, counter and err; outputs: in_ready=1, out_valid=0, out_word=0, out_count=0, err=0.
REQ-025 SHALL discard any partial frame on reset; the first beat after reset release starts a new frame.

Configuration
REQ-026 SHALL use macro POS_DECODER_RANGE_CHECK_EN.
REQ-027 SHALL, with the macro defined, set err on any accepted beat with in_pos >= OUT_WIDTH; err stays 1 until reset.
REQ-028 SHALL, without the macro, keep the err port and tie it to 0, with no range-check logic.

Structure
REQ-029 SHALL place the state enum (ACCUM, EMIT) and the default OUT_WIDTH constant in shared package pos_decoder_pkg.
REQ-030 SHALL instantiate a single combinational sub-module onehot_dec (index -> one-hot, out-of-range -> all zero).

Verification
REQ-031 SHALL cover: OUT_WIDTH=32, beats pos=3,7,31(last), out_ready=1 -> out_word=0x80000088, out_count=3, out_valid one cycle after last beat.
REQ-032 SHALL cover: beats pos=5,5(last) -> out_word=0x00000020, out_count=2.
REQ-033 SHALL cover: frame complete, out_ready=0 for 5 cycles -> out_valid, out_word, out_count stable, in_ready=0; after handshake in_ready=1 next cycle, out_word=0.
REQ-034 SHALL cover: rst_n pulsed low after 2 beats of a frame -> outputs at reset values immediately; next frame pos=0(last) -> out_word=0x00000001, out_count=1.
REQ-035 SHALL cover: OUT_WIDTH=20 with macro, beats pos=25,1(last) -> out_word=0x00002, out_count=2, err=1 held until reset; without macro err=0.
REQ-036 SHALL cover: 64 beats of pos=0 then last -> out_count saturates at 63, out_word=0x00000001.
